// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples SCK/MOSI/SS_n on the core clock, assembles MSB-first
// bytes, echoes the previous byte on MISO and reports frame boundaries, counts and truncations.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    input  logic             spi_ss_n,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic [7:0]       spi_shift_reg,
    output logic [2:0]       spi_done,
    output logic             frame_start,
    output logic             frame_end,
    output logic             spi_err,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sck_hist;
    logic                   r_ss_hist;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [2:0]             r_bit_cnt;
    logic [2:0]             w_bit_cnt_nxt;
    logic [7:0]             r_rx;
    logic [7:0]             w_rx_nxt;
    logic [7:0]             r_tx;
    logic [7:0]             r_shift_reg;
    logic                   r_byte_pulse;
    logic [2:0]             r_spi_done;
    logic                   r_miso;
    logic                   r_miso_oe;
    logic                   r_frame_start;
    logic                   r_frame_end;
    logic                   r_spi_err;
    logic [CNT_W-1:0]       r_byte_count;

    logic                   w_sck_s;
    logic                   w_ss_s;
    logic                   w_mosi;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_ss_fall;
    logic                   w_ss_rise;
    logic                   w_frame_start;
    logic                   w_frame_end;
    logic                   w_spi_err;
    logic                   w_byte_done;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_hist;
    assign w_sck_fall = ~w_sck_s & r_sck_hist;
    assign w_ss_fall  = ~w_ss_s & r_ss_hist;
    assign w_ss_rise  = w_ss_s & ~r_ss_hist;
    assign w_rx_nxt   = {r_rx[6:0], w_mosi};

    // Input synchronisers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_sync  <= {SYNC_STAGES{1'b0}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_ss_sync   <= {SYNC_STAGES{1'b1}};
            r_sck_hist  <= 1'b0;
            r_ss_hist   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            r_sck_hist  <= w_sck_s;
            r_ss_hist   <= w_ss_s;
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle frame/byte events
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_spi_err     = 1'b0;
        w_byte_done   = 1'b0;
        w_bit_cnt_nxt = r_bit_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_frame_start = 1'b1;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_sck_rise) begin
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    w_byte_done   = (r_bit_cnt == 3'd7);
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt;
                end
                // A byte finishing on the same cycle as SS_n rising is not a truncation
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                    w_spi_err   = (w_bit_cnt_nxt != 3'd0);
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Receive/transmit datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt     <= 3'd0;
            r_rx          <= 8'h00;
            r_tx          <= 8'h00;
            r_shift_reg   <= 8'h00;
            r_byte_pulse  <= 1'b0;
            r_spi_done    <= 3'b000;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_spi_err     <= 1'b0;
            r_byte_count  <= {CNT_W{1'b0}};
        end else begin
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_spi_err     <= w_spi_err;
            r_byte_pulse  <= w_byte_done;
            r_spi_done    <= {r_spi_done[1:0], r_byte_pulse};
            // MISO shows tx[7] on each SCK fall and then shifts, so the MSB already on the
            // line at frame start is pre-consumed, while a freshly loaded byte is not.
            if (w_frame_start) begin
                r_bit_cnt    <= 3'd0;
                r_byte_count <= {CNT_W{1'b0}};
                r_tx         <= {r_shift_reg[6:0], 1'b0};
                r_miso       <= r_shift_reg[7];
                r_miso_oe    <= 1'b1;
            end else if (r_state == ST_ACTIVE) begin
                r_bit_cnt <= w_frame_end ? 3'd0 : w_bit_cnt_nxt;
                if (w_sck_rise) begin
                    r_rx <= w_rx_nxt;
                    if (w_byte_done) begin
                        r_shift_reg <= w_rx_nxt;
                        r_tx        <= w_rx_nxt;
                        if (r_byte_count != CNT_MAX) begin
                            r_byte_count <= r_byte_count + CNT_ONE;
                        end
                    end
                end else if (w_sck_fall) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
                if (w_frame_end) begin
                    r_miso_oe <= 1'b0;
                end
            end
        end
    end

    assign spi_miso      = r_miso;
    assign spi_miso_oe   = r_miso_oe;
    assign spi_shift_reg = r_shift_reg;
    assign spi_done      = r_spi_done;
    assign frame_start   = r_frame_start;
    assign frame_end     = r_frame_end;
    assign spi_err       = r_spi_err;
    assign byte_count    = r_byte_count;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx: a bit-banged SPI master plus a byte-level model of the
// expected received bytes, echo data, event counts and per-frame byte count.
module tb_spi_slave_rx;

    logic       clk;
    logic       reset;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] spi_shift_reg;
    logic [2:0] spi_done;
    logic       frame_start;
    logic       frame_end;
    logic       spi_err;
    logic [7:0] byte_count;

    spi_slave_rx #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_ss_n      (spi_ss_n),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .spi_shift_reg (spi_shift_reg),
        .spi_done      (spi_done),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .spi_err       (spi_err),
        .byte_count    (byte_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observed event counts (cycles where each indication is high)
    int n_done = 0;
    int n_fs   = 0;
    int n_fe   = 0;
    int n_err  = 0;
    int n_orphan_err = 0;

    // Reference model state
    logic [7:0] exp_shreg = 8'h00;
    int exp_done = 0;
    int exp_fs   = 0;
    int exp_fe   = 0;
    int exp_err  = 0;
    logic [7:0] frame_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (spi_done[2:1] == 2'b01) n_done++;
            if (frame_start) n_fs++;
            if (frame_end) n_fe++;
            if (spi_err) n_err++;
            if (spi_err && !frame_end) n_orphan_err++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shift the first n bits of d MSB-first, checking MISO against echo before each rise
    task automatic send_bits(input logic [7:0] d, input logic [7:0] echo, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = d[7-i];
            tick(4);
            check_eq("miso_echo", spi_miso, echo[7-i]);
            spi_sck = 1'b1;
            tick(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic check_events();
        check_eq("done_events", n_done, exp_done);
        check_eq("start_events", n_fs, exp_fs);
        check_eq("end_events", n_fe, exp_fe);
        check_eq("err_events", n_err, exp_err);
        check_eq("err_without_end", n_orphan_err, 0);
    endtask

    // One frame carrying frame_q, optionally followed by tail_bits of a truncated byte
    task automatic run_frame(input int tail_bits);
        logic [7:0] echo;
        logic [7:0] junk;
        int cnt;
        echo = exp_shreg;
        cnt  = 0;
        spi_ss_n = 1'b0;
        exp_fs++;
        tick(8);
        check_eq("oe_active", spi_miso_oe, 1'b1);
        check_eq("count_at_start", byte_count, 0);
        foreach (frame_q[i]) begin
            send_bits(frame_q[i], echo, 8);
            echo      = frame_q[i];
            exp_shreg = frame_q[i];
            exp_done++;
            if (cnt < 255) cnt++;
            check_eq("byte_count", byte_count, cnt);
            check_eq("shift_reg_byte", spi_shift_reg, exp_shreg);
        end
        if (tail_bits > 0) begin
            junk = 8'($urandom);
            send_bits(junk, echo, tail_bits);
            exp_err++;
        end
        spi_ss_n = 1'b1;
        exp_fe++;
        tick(8);
        check_eq("oe_idle", spi_miso_oe, 1'b0);
        check_eq("shift_reg_end", spi_shift_reg, exp_shreg);
        check_eq("count_end", byte_count, cnt);
        check_events();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] echo;
        int nb;
        reset    = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        spi_ss_n = 1'b1;
        tick(3);
        check_eq("rst_shift_reg", spi_shift_reg, 8'h00);
        check_eq("rst_done", spi_done, 3'b000);
        check_eq("rst_miso", spi_miso, 1'b0);
        check_eq("rst_oe", spi_miso_oe, 1'b0);
        check_eq("rst_flags", {frame_start, frame_end, spi_err}, 3'b000);
        check_eq("rst_count", byte_count, 8'd0);
        reset = 1'b0;
        tick(4);

        // SCK activity with SS_n high must be ignored
        for (int i = 0; i < 8; i++) begin
            spi_mosi = 1'($urandom);
            spi_sck  = 1'b1;
            tick(4);
            spi_sck  = 1'b0;
            tick(4);
            check_eq("idle_done", spi_done, 3'b000);
        end
        tick(4);
        check_eq("idle_oe", spi_miso_oe, 1'b0);
        check_eq("idle_shift_reg", spi_shift_reg, 8'h00);
        check_eq("idle_count", byte_count, 8'd0);
        check_events();

        // Single byte, then three bytes with echo of the previous byte
        frame_q = '{8'h41};
        run_frame(0);
        frame_q = '{8'h48, 8'h49, 8'h21};
        run_frame(0);

        // Truncated after 5 bits, then a clean byte
        frame_q = '{};
        run_frame(5);
        frame_q = '{8'h7E};
        run_frame(0);

        // Reset in the middle of a byte
        echo = exp_shreg;
        spi_ss_n = 1'b0;
        exp_fs++;
        tick(8);
        send_bits(8'hFF, echo, 4);
        reset = 1'b1;
        tick(2);
        spi_ss_n = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(8);
        exp_shreg = 8'h00;
        check_eq("post_rst_shift_reg", spi_shift_reg, 8'h00);
        check_eq("post_rst_oe", spi_miso_oe, 1'b0);
        check_eq("post_rst_count", byte_count, 8'd0);
        frame_q = '{8'hA5};
        run_frame(0);

        // SS_n rises together with the 8th SCK rise: byte completes, no error
        d    = 8'($urandom);
        echo = exp_shreg;
        spi_ss_n = 1'b0;
        exp_fs++;
        tick(8);
        send_bits(8'h3C, echo, 8);
        echo = 8'h3C;
        send_bits(d, echo, 7);
        spi_mosi = d[0];
        tick(4);
        check_eq("miso_echo_last", spi_miso, echo[0]);
        spi_sck  = 1'b1;
        spi_ss_n = 1'b1;
        tick(4);
        spi_sck = 1'b0;
        tick(8);
        exp_shreg = d;
        exp_done += 2;
        exp_fe++;
        check_eq("coinc_shift_reg", spi_shift_reg, d);
        check_eq("coinc_count", byte_count, 2);
        check_events();

        // Random frames, some truncated
        for (int f = 0; f < 5; f++) begin
            nb = $urandom_range(1, 4);
            frame_q = '{};
            for (int i = 0; i < nb; i++) frame_q.push_back(8'($urandom));
            run_frame((f % 2 == 1) ? int'($urandom_range(1, 7)) : 0);
        end

        // 256 bytes: count saturates at 255, every byte still pulses
        frame_q = '{};
        for (int i = 0; i < 256; i++) frame_q.push_back(8'($urandom));
        run_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
